muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Multi-cycle sequencer implementing the RV32M integer multiply/divide subset (MUL, DIV, DIVU, REM, REMU). Owns no adder: it drives a dedicated, purely combinational ALU instance cycle by cycle, with shift-add for multiply and restoring division for divide. Sits beside the execute stage and is reached through valid/ready request and response handshakes. Fixed, operand-independent latency.

## Interface
- No parameters; datapath is 32 bits (`int32_t`).
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE.
- `op`  in  3  0=MUL, 1=DIV, 2=DIVU, 3=REM, 4=REMU; 5–7 behave as MUL.
- `rs1`, `rs2`  in  32  operands (dividend/divisor, or multiplicand/multiplier).
- `flush`  in  1  abort current operation; no response is produced.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer accepts result.
- `resp_data`  out  32  result.
- `busy`  out  1  state != IDLE.
- `alu_a`, `alu_b`  out  32  ALU operands.
- `alu_mode`  out  `alu_mode_t`  ALU operation and signedness.
- `alu_out`  in  32  ALU result, same cycle.

## Operation
- States: IDLE, NEG_A, NEG_B, MUL_STEP, DIV_CMP, DIV_SUB, FIX, DONE.
- IDLE:
  - On `req_valid`, latch `op`/`rs1`/`rs2`, record `sign_a`/`sign_b`, go to NEG_A.
  - `sign_a`/`sign_b` are set only for DIV/REM.
- NEG_A / NEG_B:
  - ALU computes 0 − operand (ALU_SUB).
  - The result replaces the operand only when that operand's sign flag is set. Otherwise the operand is held.
  - NEG_B then goes to MUL_STEP (MUL) or DIV_CMP (divides).
- MUL_STEP, 32 iterations:
  - ALU_ADD with `acc` and (`mplier[0]` ? `mcand` : 0); `acc`←`alu_out`.
  - `mcand`<<=1; `mplier`>>=1.
  - Low 32 bits only, so there is no sign handling for MUL.
- DIV_CMP / DIV_SUB, 32 iterations each:
  - CMP: `r'`={`r`[30:0],`q`[31]}, with `carry`=`r`[31].
  - ALU does ALU_SET_LESS_THAN UNSIGNED(`r'`, divisor); `lt` = !`carry` && `alu_out`[0].
  - CMP latches `r`←`r'`, `q`←{`q`[30:0], !`lt`}.
  - SUB: if `q`[0], ALU_SUB(`r`, divisor) and `r`←`alu_out`; otherwise ALU_NULL and hold.
- 5-bit iteration counter; after the 32nd MUL_STEP or DIV_SUB, go to FIX.
- FIX: ALU_SUB(0, x) applied to the selected result:
  - DIV: quotient negated iff `sign_a`^`sign_b` and divisor != 0.
  - REM: remainder negated iff `sign_a`.
  - Other ops pass through.
  - Result is registered into `resp_data`.
- DONE: `resp_valid`=1 and held stable until `resp_ready`, then IDLE.
- Edge cases handled by the algorithm, with no special path:
  - Divide by zero gives quotient 0xFFFFFFFF and remainder = dividend.
  - 0x80000000 / −1 gives quotient 0x80000000 and remainder 0.
- `flush` in any non-IDLE state → IDLE next edge; `resp_valid` drops and no response is produced. `flush` in IDLE is ignored.
- In all non-ALU-using states, `alu_mode.operation` is ALU_NULL and `alu_a`/`alu_b` are 0.

## Timing
- Reset (async assert, sync release):
  - State IDLE, `req_ready`=1, `resp_valid`=0, `resp_data`=0, `busy`=0.
  - All internal registers 0; `alu_mode` = ALU_NULL.
- Accept edge E0 = rising edge with `req_valid`&&`req_ready`.
- `resp_valid` rises at edge E0+35 for MUL and E0+67 for DIV/DIVU/REM/REMU, independent of operand values.
- `req_ready` is low from E0 until the edge after the response handshake. No request is accepted in the handshake cycle.
- `resp_data` changes only on the FIX→DONE edge.
- `flush` takes priority over all transitions, including DONE with `resp_ready` high.
- ALU path is combinational within one cycle: `alu_a`/`alu_b`/`alu_mode` come from registered state only; `alu_out` is captured at the next edge.

## Test plan
- Reset mid-DIV (assert `rst_n` low at E0+20) → outputs at reset values immediately; a subsequent MUL 7×6 returns 42 at E0'+35.
- MUL −7 (0xFFFFFFF9) × 3 → 0xFFFFFFEB at exactly E0+35; `busy` high E0..E0+35.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2; each at E0+67.
- DIVU 100/0 → 0xFFFFFFFF; DIV −5/0 → 0xFFFFFFFF; REM −5/0 → 0xFFFFFFFB; DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0.
- Hold `resp_ready`=0 for 10 cycles after DONE → `resp_valid` and `resp_data` stable, `req_ready`=0; raise → IDLE next edge.
- `flush` at E0+10 of a DIV → IDLE at E0+11, no `resp_valid`; a new request accepted at E0+11 completes with the correct result.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M MUL/DIV/DIVU/REM/REMU sequencer driving an external combinational ALU.
// alu_mode = {is_signed, operation[2:0]}; operation 0=NULL, 1=ADD, 2=SUB, 3=SET_LESS_THAN.
module muldiv_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        busy,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_mode,
  input  logic [31:0] alu_out
);

  localparam logic [2:0] AluNull = 3'd0;
  localparam logic [2:0] AluAdd  = 3'd1;
  localparam logic [2:0] AluSub  = 3'd2;
  localparam logic [2:0] AluSlt  = 3'd3;

  localparam logic [2:0] OpDiv  = 3'd1;
  localparam logic [2:0] OpDivu = 3'd2;
  localparam logic [2:0] OpRem  = 3'd3;
  localparam logic [2:0] OpRemu = 3'd4;

  typedef enum logic [2:0] {
    StIdle, StNegA, StNegB, StMulStep, StDivCmp, StDivSub, StFix, StDone
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  // a: multiplicand / dividend-then-quotient; b: multiplier / divisor; acc: product / remainder
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  logic [31:0] resp_data_q, resp_data_d;

  logic        is_mul, is_quot, req_signed;
  logic [31:0] r_shift, fix_in;
  logic        lt, fix_neg;

  assign req_signed = (op == OpDiv) || (op == OpRem);
  assign is_mul     = !((op_q == OpDiv) || (op_q == OpDivu) || (op_q == OpRem) ||
                        (op_q == OpRemu));
  assign is_quot    = (op_q == OpDiv) || (op_q == OpDivu);

  // The bit shifted out of r is the 33rd bit of the partial remainder.
  assign r_shift = {acc_q[30:0], a_q[31]};
  assign lt      = !acc_q[31] && alu_out[0];

  assign fix_in  = is_quot ? a_q : acc_q;
  assign fix_neg = ((op_q == OpDiv) && (sign_a_q ^ sign_b_q) && (b_q != 32'd0)) ||
                   ((op_q == OpRem) && sign_a_q);

  assign req_ready  = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign resp_valid = (state_q == StDone);
  assign resp_data  = resp_data_q;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    resp_data_d = resp_data_q;
    alu_a       = 32'd0;
    alu_b       = 32'd0;
    alu_mode    = {1'b0, AluNull};

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_d     = op;
          a_d      = rs1;
          b_d      = rs2;
          acc_d    = 32'd0;
          cnt_d    = 5'd0;
          sign_a_d = req_signed && rs1[31];
          sign_b_d = req_signed && rs2[31];
          state_d  = StNegA;
        end
      end
      StNegA: begin
        alu_mode = {1'b0, AluSub};
        alu_b    = a_q;
        if (sign_a_q) a_d = alu_out;
        state_d = StNegB;
      end
      StNegB: begin
        alu_mode = {1'b0, AluSub};
        alu_b    = b_q;
        if (sign_b_q) b_d = alu_out;
        state_d = is_mul ? StMulStep : StDivCmp;
      end
      StMulStep: begin
        alu_mode = {1'b0, AluAdd};
        alu_a    = acc_q;
        alu_b    = b_q[0] ? a_q : 32'd0;
        acc_d    = alu_out;
        a_d      = {a_q[30:0], 1'b0};
        b_d      = {1'b0, b_q[31:1]};
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = StFix;
      end
      StDivCmp: begin
        alu_mode = {1'b0, AluSlt};
        alu_a    = r_shift;
        alu_b    = b_q;
        acc_d    = r_shift;
        a_d      = {a_q[30:0], !lt};
        state_d  = StDivSub;
      end
      StDivSub: begin
        if (a_q[0]) begin
          alu_mode = {1'b0, AluSub};
          alu_a    = acc_q;
          alu_b    = b_q;
          acc_d    = alu_out;
        end
        cnt_d   = cnt_q + 5'd1;
        state_d = (cnt_q == 5'd31) ? StFix : StDivCmp;
      end
      StFix: begin
        alu_mode    = {1'b0, AluSub};
        alu_b       = fix_in;
        resp_data_d = fix_neg ? alu_out : fix_in;
        state_d     = StDone;
      end
      StDone: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over every transition and must not disturb the last result.
    if (flush && (state_q != StIdle)) begin
      state_d     = StIdle;
      resp_data_d = resp_data_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_q        <= 3'd0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      acc_q       <= 32'd0;
      cnt_q       <= 5'd0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      resp_data_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      resp_data_q <= resp_data_d;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed RV32M cases plus random ops against an
// arithmetic reference model; the ALU the sequencer drives is modelled here.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs1 = 32'd0;
  logic [31:0] rs2 = 32'd0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic        busy;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_mode;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int rr_mode = 1;  // 0: resp_ready low, 1: high, 2: random

  typedef struct {
    logic [31:0] data;
    int          e0;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  muldiv_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .op         (op),
    .rs1        (rs1),
    .rs2        (rs2),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .busy       (busy),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_mode   (alu_mode),
    .alu_out    (alu_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    alu_out = 32'd0;
    case (alu_mode[2:0])
      3'd1: alu_out = alu_a + alu_b;
      3'd2: alu_out = alu_a - alu_b;
      3'd3: alu_out = alu_mode[3] ? {31'd0, $signed(alu_a) < $signed(alu_b)}
                                  : {31'd0, alu_a < alu_b};
      default: alu_out = 32'd0;
    endcase
  end

  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       resp_ready = 1'b0;
      1:       resp_ready = 1'b1;
      default: resp_ready = ($urandom_range(0, 2) != 0);
    endcase
  end

  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (o)
      3'd1: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        return sa / sb;
      end
      3'd2: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd3: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        return sa % sb;
      end
      3'd4: return (b == 0) ? a : a % b;
      default: return a * b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] o);
    return (o >= 3'd1 && o <= 3'd4) ? 67 : 35;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic abort_timeout(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  endtask

  // Monitor: latency on rise, stability while stalled, data on handshake.
  logic        prev_hold = 1'b0;
  logic [31:0] prev_data = 32'd0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          if (!prev_hold) check("unexpected_resp", {31'd0, resp_valid}, 32'd0);
        end else begin
          if (!prev_hold) check("resp_latency", cyc - exp_q[0].e0, exp_q[0].lat);
          else check("resp_stable", resp_data, prev_data);
          if (resp_ready) begin
            check("resp_data", resp_data, exp_q[0].data);
            void'(exp_q.pop_front());
          end
        end
      end
      prev_hold = resp_valid && !resp_ready;
      prev_data = resp_data;
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit push, output int e0);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!req_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) abort_timeout("issue_ready");
    req_valid = 1'b1;
    op = o;
    rs1 = a;
    rs2 = b;
    @(posedge clk);
    #1;
    e0 = cyc;
    req_valid = 1'b0;
    if (push) begin
      e.data = ref_result(o, a, b);
      e.e0 = e0;
      e.lat = ref_lat(o);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    bit busy_ok = 1'b1;
    @(negedge clk);
    while (!req_ready && n < 400) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    if (n >= 400) abort_timeout("op_complete");
    check("busy_held", {31'd0, busy_ok}, 32'd1);
    check("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int e0;
    issue(o, a, b, 1'b1, e0);
    wait_done();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_resp_data"}, resp_data, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_alu_mode"}, {28'd0, alu_mode}, 32'd0);
    check({tag, "_alu_a"}, alu_a, 32'd0);
    check({tag, "_alu_b"}, alu_b, 32'd0);
  endtask

  initial begin
    int e0;
    int n;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Directed arithmetic cases, including divide-by-zero and signed overflow.
    run(3'd0, 32'hFFFFFFF9, 32'd3);
    run(3'd1, 32'hFFFFFFF9, 32'd2);
    run(3'd3, 32'hFFFFFFF9, 32'd2);
    run(3'd2, 32'd100, 32'd7);
    run(3'd4, 32'd100, 32'd7);
    run(3'd2, 32'd100, 32'd0);
    run(3'd1, 32'hFFFFFFFB, 32'd0);
    run(3'd3, 32'hFFFFFFFB, 32'd0);
    run(3'd1, 32'h80000000, 32'hFFFFFFFF);
    run(3'd3, 32'h80000000, 32'hFFFFFFFF);
    run(3'd6, 32'd12345, 32'd678);

    // Backpressure: result held for 10 cycles, then released.
    rr_mode = 0;
    issue(3'd2, 32'd100, 32'd7, 1'b1, e0);
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) abort_timeout("bp_resp_valid");
    for (int i = 0; i < 10; i++) begin
      check("bp_req_ready", {31'd0, req_ready}, 32'd0);
      check("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
      check("bp_resp_data", resp_data, 32'd14);
      @(negedge clk);
    end
    rr_mode = 1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("bp_idle_after_hs", {31'd0, req_ready}, 32'd1);

    // Flush mid-divide: no response, sequencer idle next edge, next op correct.
    issue(3'd1, 32'd1000, 32'd3, 1'b0, e0);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_req_ready", {31'd0, req_ready}, 32'd1);
    check("flush_resp_valid", {31'd0, resp_valid}, 32'd0);
    run(3'd3, 32'hFFFFFC18, 32'd7);

    // Asynchronous reset in the middle of a divide.
    issue(3'd1, 32'd100, 32'd7, 1'b0, e0);
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    run(3'd0, 32'd7, 32'd6);

    // Random ops with random consumer backpressure.
    rr_mode = 2;
    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
        0:       ra = 32'h80000000;
        1:       ra = $urandom_range(0, 20);
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      run(ro, ra, rb);
    end
    rr_mode = 1;

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
